// File: rtl/modn_updown_counter_pkg.sv
// modn_updown_counter_pkg: shared helpers and types for the mod-N counter family
package modn_pkg;

    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/modn_updown_counter_if.sv
// modn_updown_counter_if: control/status bundle of the counter; mod_in exists only with MODN_RUNTIME_MOD_EN
interface modn_updown_counter_if #(parameter int WIDTH = 4);

    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
`ifdef MODN_RUNTIME_MOD_EN
    logic [WIDTH-1:0] mod_in;
`endif
    logic [WIDTH-1:0] counter;
    logic             tc;
    logic             zero;

    modport master (
`ifdef MODN_RUNTIME_MOD_EN
        output mod_in,
`endif
        output en, up, load, load_val,
        input  counter, tc, zero
    );

    modport slave (
`ifdef MODN_RUNTIME_MOD_EN
        input  mod_in,
`endif
        input  en, up, load, load_val,
        output counter, tc, zero
    );

endinterface

// File: rtl/modn_updown_counter_next_calc.sv
// modn_next_calc: combinational next count and terminal-count strobe, expressed against last = M-1
module modn_next_calc
    import modn_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] last_i,
    input  logic             up_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    dir_e dir;
    logic wrap;

    // wrap covers both the normal wrap point and an out-of-range count left by a modulus shrink
    always_comb begin
        dir     = dir_e'(up_i);
        wrap    = (dir == DIR_UP) ? (count_i >= last_i) : (count_i == '0 || count_i > last_i);
        tc_o    = en_i & ~load_i & wrap;
        count_o = load_i ? ((load_val_i > last_i) ? last_i : load_val_i)
                : !en_i ? count_i
                : (dir == DIR_UP) ? (wrap ? '0 : count_i + WIDTH'(1))
                : (wrap ? last_i : count_i - WIDTH'(1));
    end

endmodule

// File: rtl/modn_updown_counter.sv
// modn_updown_counter: mod-N up/down counter with load and chainable tc; MODN_RUNTIME_MOD_EN adds run-time modulus
module modn_updown_counter
    import modn_pkg::*;
#(
    parameter int N     = 15,
    parameter int WIDTH = clog2(N)
) (
    input logic                   clk,
    input logic                   reset,
    modn_updown_counter_if.slave  bus
);

    logic [WIDTH-1:0] counter_q;
    logic [WIDTH-1:0] counter_d;
    logic [WIDTH-1:0] last;

`ifdef MODN_RUNTIME_MOD_EN
    // mod_in of 0 or 1 both behave as a modulus of 1
    assign last = (bus.mod_in < WIDTH'(2)) ? '0 : bus.mod_in - WIDTH'(1);
`else
    localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);
    assign last = LAST;
`endif

    modn_next_calc #(.WIDTH(WIDTH)) u_next (
        .count_i    (counter_q),
        .last_i     (last),
        .up_i       (bus.up),
        .en_i       (bus.en),
        .load_i     (bus.load),
        .load_val_i (bus.load_val),
        .count_o    (counter_d),
        .tc_o       (bus.tc)
    );

    // count register; reset clears it without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) counter_q <= '0;
        else       counter_q <= counter_d;
    end

    assign bus.counter = counter_q;
    assign bus.zero    = (counter_q == '0);

endmodule

// File: tb/tb_modn_updown_counter.sv
// tb_modn_updown_counter: directed scenarios plus random traffic against an arithmetic reference (honours MODN_RUNTIME_MOD_EN)
module tb_modn_updown_counter;

    localparam int N = 15;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cnt = 0;

    modn_updown_counter_if #(.WIDTH(W)) bus ();

    modn_updown_counter #(.N(N), .WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (model count %0d, t=%0t)", tag, got, exp, cnt, $time);
        end
    endtask

    function automatic int eff_m();
`ifdef MODN_RUNTIME_MOD_EN
        return (bus.mod_in < 2) ? 1 : int'(bus.mod_in);
`else
        return N;
`endif
    endfunction

    task automatic drive(input bit en, input bit up, input bit load, input int lv);
        bus.en = en;
        bus.up = up;
        bus.load = load;
        bus.load_val = W'(lv);
    endtask

    task automatic tick();
        int m, nxt;
        bit tc;
        #1;
        m = eff_m();
        tc = 0;
        if (bus.load) nxt = (int'(bus.load_val) < m) ? int'(bus.load_val) : m - 1;
        else if (!bus.en) nxt = cnt;
        else if (bus.up) begin
            nxt = (cnt >= m) ? 0 : (cnt + 1) % m;
            tc = (nxt == 0);
        end else begin
            tc = (cnt == 0 || cnt >= m);
            nxt = tc ? m - 1 : cnt - 1;
        end
        chk("counter", int'(bus.counter), cnt);
        chk("zero", int'(bus.zero), int'(cnt == 0));
        chk("tc", int'(bus.tc), int'(tc));
        @(posedge clk);
        cnt = nxt;
        #1;
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        cnt = 0;
        chk("async_counter", int'(bus.counter), 0);
        chk("async_zero", int'(bus.zero), 1);
        reset = 1'b0;
    endtask

    initial begin
        drive(0, 1, 0, 0);
`ifdef MODN_RUNTIME_MOD_EN
        bus.mod_in = W'(N);
`endif
        #3;
        chk("reset_counter", int'(bus.counter), 0);
        chk("reset_zero", int'(bus.zero), 1);
        chk("reset_tc", int'(bus.tc), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        // load 7 then assert reset between edges
        drive(0, 1, 1, 7);
        tick();
        drive(0, 1, 0, 0);
        tick();
        async_reset();
        // full up cycle through the wrap
        drive(1, 1, 0, 0);
        for (int i = 0; i < 16; i++) tick();
        // down from 0, then reverse at 5
        drive(1, 1, 1, 0);
        tick();
        drive(1, 0, 0, 0);
        for (int i = 0; i < 20 && cnt != 5; i++) tick();
        chk("reached5", cnt, 5);
        drive(1, 1, 0, 0);
        tick();
        drive(0, 1, 0, 0);
        tick();
        // load wins over en, and clamps out-of-range values
        drive(1, 1, 1, 9);
        tick();
        drive(1, 1, 1, 15);
        tick();
        drive(0, 1, 0, 0);
        tick();
        // enable pattern 1,0,0,1 from 3
        drive(0, 1, 1, 3);
        tick();
        drive(1, 1, 0, 0); tick();
        drive(0, 1, 0, 0); tick();
        drive(0, 1, 0, 0); tick();
        drive(1, 1, 0, 0); tick();
        drive(0, 1, 0, 0); tick();
`ifdef MODN_RUNTIME_MOD_EN
        // shrink modulus below the current count, then collapse it to 1
        bus.mod_in = W'(15);
        drive(0, 1, 1, 12);
        tick();
        bus.mod_in = W'(10);
        drive(1, 1, 0, 0);
        tick();
        bus.mod_in = W'(1);
        for (int i = 0; i < 4; i++) begin
            drive(i % 3 != 2, i[0], 0, 0);
            tick();
        end
        bus.mod_in = W'(0);
        drive(1, 0, 0, 0);
        tick();
        bus.mod_in = W'(N);
`endif
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom % 4) != 0, $urandom % 2, ($urandom % 8) == 0, int'($urandom % 16));
`ifdef MODN_RUNTIME_MOD_EN
            if ($urandom % 8 == 0) bus.mod_in = W'($urandom % 16);
`endif
            if ($urandom % 64 == 0) async_reset();
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
